// File: rtl/spi_pkg.sv
// spi_pkg: shared state, register-address and TX-entry types for the SPI MMIO master
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} spi_state_t;
  localparam logic SPI_DATA_ADDR = 1'b0;
  localparam logic SPI_STAT_ADDR = 1'b1;
  typedef struct packed {
    logic       ignore;
    logic [7:0] data;
  } tx_entry_t;
endpackage

// File: rtl/spi_mmio_master_if.sv
// spi_mmio_master_if: CPU-side MMIO access and status signals of the SPI master
interface spi_mmio_master_if;
  logic       spi_wr;
  logic       spi_rd;
  logic       spi_addr;
  logic [7:0] spi_din;
  logic       spi_ignore_response;
  logic [7:0] spi_dout;
  logic       spi_data_avail;
  logic       spi_buffer_empty;
  logic       spi_buffer_full;
  modport master (
    output spi_wr, spi_rd, spi_addr, spi_din, spi_ignore_response,
    input  spi_dout, spi_data_avail, spi_buffer_empty, spi_buffer_full
  );
  modport slave (
    input  spi_wr, spi_rd, spi_addr, spi_din, spi_ignore_response,
    output spi_dout, spi_data_avail, spi_buffer_empty, spi_buffer_full
  );
endinterface

// File: rtl/spi_mmio_master_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a push while full succeeds only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/spi_mmio_master.sv
// spi_mmio_master: MMIO SPI mode-0 master with TX/RX FIFOs and controller status flags
module spi_mmio_master import spi_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic clk,
  input  logic rst,
  spi_mmio_master_if.slave bus,
  output logic sclk,
  output logic mosi,
  output logic cs_n,
  input  logic miso
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  spi_state_t state_q, state_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rx_q, rx_d, rx_dout;
  logic [DW-1:0] div_q, div_d;
  logic [4:0] half_q, half_d;
  logic ign_q, ign_d, sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic tx_push, tx_pop, tx_empty, tx_full, tx_avail, rx_push, rx_pop, rx_empty, rx_full;
  tx_entry_t tx_din, tx_dout;
  assign tx_din = '{ignore: bus.spi_ignore_response, data: bus.spi_din};
  sync_fifo #(.WIDTH($bits(tx_entry_t)), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .din(tx_din), .pop(tx_pop),
    .dout(tx_dout), .empty(tx_empty), .full(tx_full)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_q), .pop(rx_pop),
    .dout(rx_dout), .empty(rx_empty), .full(rx_full)
  );
  assign bus.spi_dout         = rx_empty ? 8'h00 : rx_dout;
  assign bus.spi_data_avail   = ~rx_empty;
  assign bus.spi_buffer_full  = tx_full;
  assign bus.spi_buffer_empty = tx_empty & (state_q == IDLE);
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;
  always_comb begin
    tx_push  = bus.spi_wr & (bus.spi_addr == SPI_DATA_ADDR) & ~tx_full;
    rx_pop   = bus.spi_rd & (bus.spi_addr == SPI_DATA_ADDR);
    tx_avail = ~tx_empty | tx_push;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    state_d  = state_q;
    shift_d  = shift_q;
    rx_d     = rx_q;
    div_d    = div_q;
    half_d   = half_q;
    ign_d    = ign_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    case (state_q)
      IDLE: state_d = tx_avail ? LOAD : IDLE;
      LOAD: begin
        tx_pop  = 1'b1;
        state_d = SHIFT;
        shift_d = tx_dout.data[6:0];
        mosi_d  = tx_dout.data[7];
        ign_d   = tx_dout.ignore;
        cs_n_d  = 1'b0;
        div_d   = '0;
        half_d  = '0;
      end
      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          half_d = half_q + 1'b1;
          rx_d   = sclk_q ? rx_q : {rx_q[6:0], miso};
          mosi_d = sclk_q ? shift_q[6] : mosi_q;
          shift_d = sclk_q ? {shift_q[5:0], 1'b0} : shift_q;
          state_d = half_q == 5'd15 ? DONE : SHIFT;
        end
      end
      DONE: begin
        rx_push = ~ign_q & (~rx_full | rx_pop);
        state_d = tx_avail ? LOAD : IDLE;
        cs_n_d  = ~tx_avail;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      rx_q    <= '0;
      div_q   <= '0;
      half_q  <= '0;
      ign_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      div_q   <= div_d;
      half_q  <= half_d;
      ign_q   <= ign_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
    end
  end
endmodule

// File: tb/tb_spi_mmio_master.sv
// tb_spi_mmio_master: directed loopback bench with an RX scoreboard for spi_mmio_master
module tb_spi_mmio_master;
  logic clk = 1'b0, rst = 1'b1, sclk, mosi, cs_n, miso;
  int compared = 0, mismatched = 0;
  logic [7:0] q[$];
  logic [7:0] d, bits;
  int n, rises, toggles, cs_hi;
  logic prev;
  spi_mmio_master_if bus();
  assign miso = mosi;
  spi_mmio_master #(.FIFO_DEPTH(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic write_byte(input logic [7:0] v, input logic ign);
    bus.spi_wr = 1'b1;
    bus.spi_addr = 1'b0;
    bus.spi_din = v;
    bus.spi_ignore_response = ign;
    tick();
    bus.spi_wr = 1'b0;
  endtask
  task automatic read_byte(output logic [7:0] v);
    bus.spi_rd = 1'b1;
    bus.spi_addr = 1'b0;
    #1;
    v = bus.spi_dout;
    tick();
    bus.spi_rd = 1'b0;
  endtask
  task automatic read_check(input string tag);
    logic [7:0] v;
    logic [7:0] e;
    e = q.size() > 0 ? q.pop_front() : 8'h00;
    read_byte(v);
    chk(tag, v, e);
  endtask
  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (!bus.spi_buffer_empty && k < budget) begin
      tick();
      k++;
    end
    chk(tag, k < budget, 1);
  endtask
  initial begin
    bus.spi_wr = 1'b0;
    bus.spi_rd = 1'b0;
    bus.spi_addr = 1'b0;
    bus.spi_din = 8'h00;
    bus.spi_ignore_response = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_empty", bus.spi_buffer_empty, 1);
    chk("rst_avail", bus.spi_data_avail, 0);
    chk("rst_full", bus.spi_buffer_full, 0);
    chk("rst_dout", bus.spi_dout, 8'h00);
    // single byte, loopback, exact latency
    write_byte(8'hA5, 1'b0);
    q.push_back(8'hA5);
    chk("a5_cs_n_still_hi", cs_n, 1);
    tick();
    chk("a5_cs_n_lo", cs_n, 0);
    n = 1; rises = 0; bits = 8'h00; prev = sclk; cs_hi = 0;
    while (!bus.spi_data_avail && n < 80) begin
      tick();
      n++;
      if (sclk && !prev) begin
        bits = {bits[6:0], mosi};
        rises++;
      end
      prev = sclk;
      if (!bus.spi_data_avail && cs_n) cs_hi++;
    end
    chk("a5_latency", n, 34);
    chk("a5_mosi_bits", bits, 8'hA5);
    chk("a5_rises", rises, 8);
    chk("a5_cs_n_held", cs_hi, 0);
    chk("a5_avail", bus.spi_data_avail, 1);
    chk("a5_peek", bus.spi_dout, q[0]);
    chk("a5_empty_done", bus.spi_buffer_empty, 1);
    chk("a5_cs_n_release", cs_n, 1);
    read_check("a5_read");
    chk("a5_avail_after", bus.spi_data_avail, 0);
    chk("a5_dout_after", bus.spi_dout, 8'h00);
    // ignored response
    write_byte(8'h3C, 1'b1);
    chk("3c_busy", bus.spi_buffer_empty, 0);
    wait_idle(60, "3c_timeout");
    chk("3c_avail", bus.spi_data_avail, 0);
    chk("3c_sclk_idle", sclk, 0);
    // back-to-back burst with TX overflow, reading as bytes arrive
    for (int i = 1; i <= 10; i++) begin
      write_byte(8'(i), 1'b0);
      if (i <= 9) q.push_back(8'(i));
      if (i == 8) chk("burst_full_8th", bus.spi_buffer_full, 0);
      if (i == 9) chk("burst_full_9th", bus.spi_buffer_full, 1);
    end
    chk("burst_full_10th", bus.spi_buffer_full, 1);
    cs_hi = 0;
    for (int i = 0; i < 9; i++) begin
      n = 0;
      while (!bus.spi_data_avail && n < 80) begin
        tick();
        n++;
        if (!bus.spi_data_avail && cs_n) cs_hi++;
      end
      chk("burst_timeout", n < 80, 1);
      read_check("burst_read");
    end
    chk("burst_cs_n_held", cs_hi, 0);
    wait_idle(80, "burst_idle_timeout");
    chk("burst_10th_dropped", bus.spi_data_avail, 0);
    chk("burst_sb_empty", q.size(), 0);
    // RX overflow with nobody reading
    for (int i = 1; i <= 9; i++) begin
      write_byte(8'(i), 1'b0);
      if (q.size() < 8) q.push_back(8'(i));
    end
    wait_idle(400, "rxovf_timeout");
    chk("rxovf_avail", bus.spi_data_avail, 1);
    for (int i = 0; i < 8; i++) read_check("rxovf_read");
    chk("rxovf_drained", bus.spi_data_avail, 0);
    read_check("rxovf_extra");
    // reset mid-transfer after seven half-periods
    write_byte(8'h77, 1'b0);
    write_byte(8'h55, 1'b0);
    toggles = 0; n = 0; prev = sclk;
    while (toggles < 7 && n < 100) begin
      tick();
      n++;
      if (sclk !== prev) toggles++;
      prev = sclk;
    end
    chk("mid_timeout", n < 100, 1);
    chk("mid_sclk_hi", sclk, 1);
    rst = 1'b1;
    tick();
    chk("mid_cs_n", cs_n, 1);
    chk("mid_sclk", sclk, 0);
    chk("mid_empty", bus.spi_buffer_empty, 1);
    chk("mid_full", bus.spi_buffer_full, 0);
    chk("mid_avail", bus.spi_data_avail, 0);
    rst = 1'b0;
    repeat (40) tick();
    chk("mid_no_push", bus.spi_data_avail, 0);
    chk("mid_still_idle", cs_n, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
